// File: rtl/arp_query_arbiter.sv
// -----------------------------------------------------------------------------
// arp_query_arbiter
//
// Shares the ARP cache's single query channel between NUM_REQ transmit-path
// requesters. Requesters are served round-robin, one transaction at a time.
// A cache miss triggers an ARP request to the ARP TX block, a fixed wait and
// a re-query, repeated up to RETRY_MAX times. After that the requester gets
// either the resolved MAC or an error.
//
// Ports
//   logic_clk / logic_rst_n     clock, asynchronous active-low reset
//   req_ip_in[32*NUM_REQ]       query IP per requester (requester i at [32i+:32])
//   req_valid_in[NUM_REQ]       query valid per requester
//   req_ready_out[NUM_REQ]      one-cycle acceptance pulse to the granted requester
//   rsp_mac_out[48]             resolved MAC (0 outside DELIVER or on error)
//   rsp_err_out                 1 = still unresolved after all retries
//   rsp_valid_out[NUM_REQ]      response valid to the granted requester only
//   rsp_ready_in[NUM_REQ]       response accept per requester
//   arp_query_*                 query channel toward the ARP cache
//   arp_response_*              response channel from the ARP cache
//   arp_request_*               ARP request trigger toward ARP TX
//   busy_out                    high whenever a transaction is in progress
//
// All handshake outputs are decoded from the state register and the
// registered grant index only, so none of them depends combinationally on
// an input.
// -----------------------------------------------------------------------------
module arp_query_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int RETRY_MAX   = 3,
    parameter int WAIT_CYCLES = 125000
) (
    input  logic                    logic_clk,
    input  logic                    logic_rst_n,
    input  logic [32*NUM_REQ-1:0]   req_ip_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    output logic [47:0]             rsp_mac_out,
    output logic                    rsp_err_out,
    output logic [NUM_REQ-1:0]      rsp_valid_out,
    input  logic [NUM_REQ-1:0]      rsp_ready_in,
    output logic [31:0]             arp_query_ip_out,
    output logic                    arp_query_valid_out,
    input  logic                    arp_query_ready_in,
    input  logic [47:0]             arp_response_mac_in,
    input  logic                    arp_response_valid_in,
    input  logic                    arp_response_err_in,
    output logic                    arp_response_ready_out,
    output logic [31:0]             arp_request_ip_out,
    output logic                    arp_request_valid_out,
    input  logic                    arp_request_ready_in,
    output logic                    busy_out
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(WAIT_CYCLES + 1);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    // Last grant resets to the top requester so requester 0 wins first.
    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TIMER_LOAD     = TW'(WAIT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM      = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_QUERY   = 3'd2,
        ST_RESP    = 3'd3,
        ST_ARP_REQ = 3'd4,
        ST_WAIT    = 3'd5,
        ST_DELIVER = 3'd6
    } state_t;

    state_t          state_q,      state_d;
    logic [GW-1:0]   g_q,          g_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     ip_q,         ip_d;
    logic [47:0]     mac_q,        mac_d;
    logic            err_q,        err_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic [RW-1:0]   retry_q,      retry_d;

    logic [GW-1:0]      pick_s;
    logic [GW-1:0]      cand_s;
    logic               any_req_s;
    logic [NUM_REQ-1:0] grant_onehot_s;
    logic [31:0]        grant_ip_s;
    logic               grant_rsp_ready_s;

    // Requester index `off` positions above `base`, wrapping at NUM_REQ.
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int sum;
        sum = 32'(base) + off;
        return GW'(sum % NUM_REQ);
    endfunction

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick_s    = last_grant_q;
        cand_s    = {GW{1'b0}};
        any_req_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s    = wrap_idx(last_grant_q, k);
            pick_s    = (!any_req_s && req_valid_in[cand_s]) ? cand_s : pick_s;
            any_req_s = any_req_s | req_valid_in[cand_s];
        end
    end

    // Decode the registered grant index into a one-hot mask and its IP lane.
    always_comb begin
        grant_onehot_s = {NUM_REQ{1'b0}};
        grant_ip_s     = 32'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot_s[i] = (g_q == GW'(i));
            grant_ip_s        = (g_q == GW'(i)) ? req_ip_in[i*32 +: 32] : grant_ip_s;
        end
        grant_rsp_ready_s = |(rsp_ready_in & grant_onehot_s);
    end

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_grant_d = last_grant_q;
        ip_d         = ip_q;
        mac_d        = mac_q;
        err_d        = err_q;
        timer_d      = timer_q;
        retry_d      = retry_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    g_d     = pick_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                ip_d    = grant_ip_s;
                retry_d = {RW{1'b0}};
                state_d = ST_QUERY;
            end

            ST_QUERY: begin
                if (arp_query_ready_in) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_QUERY;
                end
            end

            ST_RESP: begin
                if (arp_response_valid_in) begin
                    if (!arp_response_err_in) begin
                        mac_d   = arp_response_mac_in;
                        err_d   = 1'b0;
                        state_d = ST_DELIVER;
                    end else if (retry_q < RETRY_LIM) begin
                        state_d = ST_ARP_REQ;
                    end else begin
                        // Retries exhausted: report a zero MAC with the error flag.
                        mac_d   = 48'h0;
                        err_d   = 1'b1;
                        state_d = ST_DELIVER;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end

            ST_ARP_REQ: begin
                // The timer is loaded only once ARP TX accepts, so backpressure
                // here never eats into the wait period.
                if (arp_request_ready_in) begin
                    timer_d = TIMER_LOAD;
                    retry_d = (retry_q < RETRY_LIM) ? (retry_q + RW'(1'b1)) : retry_q;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ARP_REQ;
                end
            end

            ST_WAIT: begin
                if (timer_q == {TW{1'b0}}) begin
                    state_d = ST_QUERY;
                end else begin
                    timer_d = timer_q - TW'(1'b1);
                    state_d = ST_WAIT;
                end
            end

            ST_DELIVER: begin
                if (grant_rsp_ready_s) begin
                    last_grant_d = g_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DELIVER;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q      <= ST_IDLE;
            g_q          <= {GW{1'b0}};
            last_grant_q <= LAST_GRANT_RST;
            ip_q         <= 32'h0;
            mac_q        <= 48'h0;
            err_q        <= 1'b0;
            timer_q      <= {TW{1'b0}};
            retry_q      <= {RW{1'b0}};
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
            ip_q         <= ip_d;
            mac_q        <= mac_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
        end
    end

    assign req_ready_out          = (state_q == ST_GRANT)   ? grant_onehot_s : {NUM_REQ{1'b0}};
    assign rsp_valid_out          = (state_q == ST_DELIVER) ? grant_onehot_s : {NUM_REQ{1'b0}};
    assign rsp_mac_out            = (state_q == ST_DELIVER) ? mac_q : 48'h0;
    assign rsp_err_out            = (state_q == ST_DELIVER) ? err_q : 1'b0;
    assign arp_query_valid_out    = (state_q == ST_QUERY);
    assign arp_query_ip_out       = (state_q == ST_QUERY) ? ip_q : 32'h0;
    assign arp_response_ready_out = (state_q == ST_RESP);
    assign arp_request_valid_out  = (state_q == ST_ARP_REQ);
    assign arp_request_ip_out     = ip_q;
    assign busy_out               = (state_q != ST_IDLE);

endmodule
